ps2_scancode_rx: RTL and testbench

//  PS/2 keyboard receiver that feeds the key-command decoder (switch_mode) in the production-test top level.

---
 rtl/ps2_scancode_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitching, 11-bit frame
// deserialisation and E0/F0 prefix folding into one event per scan code.
module ps2_scancode_rx #(
   parameter int CLKFREQ_KHZ = 7000,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_US  = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clkps2,
   input  logic       dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       code_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam int          TMO_MAX   = CLKFREQ_KHZ * TIMEOUT_US / 1000;
   localparam logic [15:0] TMO_LAST  = 16'(TMO_MAX - 1);
   localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        clk_s_p0, clk_s_p1;
   logic        dat_s_p0, dat_s_p1;
   logic        clk_filt;
   logic [3:0]  filt_cnt;
   logic        fall;
   logic [2:0]  bitcnt;
   logic [7:0]  shreg;
   logic        par_ok;
   logic [15:0] tmo_cnt;
   logic        ext_pend, rel_pend;
   logic        byte_ok;
   logic        err;

   // Two-flop synchronisers for both asynchronous PS/2 pins (idle level is 1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s_p0 <= 1'b1;
         clk_s_p1 <= 1'b1;
         dat_s_p0 <= 1'b1;
         dat_s_p1 <= 1'b1;
      end else begin
         clk_s_p0 <= clkps2;
         clk_s_p1 <= clk_s_p0;
         dat_s_p0 <= dataps2;
         dat_s_p1 <= dat_s_p0;
      end
   end

   // Deglitch filter: accept a new ps2clk level only after FILTER_LEN agreeing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= 4'd0;
      end else if (clk_s_p1 != clk_filt) begin
         if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s_p1;
            filt_cnt <= 4'd0;
         end else begin
            filt_cnt <= filt_cnt + 4'd1;
         end
      end else begin
         filt_cnt <= 4'd0;
      end
   end

   // Falling edge is flagged in the same cycle the filtered clock commits to 0,
   // so the synced data bit is taken exactly at the accepted edge.
   assign fall = clk_filt & ~clk_s_p1 & (filt_cnt == FILT_LAST);
   assign busy = (state != IDLE);

   // Frame FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, byte acceptance and abort detection (timeout wins unless an edge arrives)
   always_comb begin
      state_nxt = state;
      byte_ok   = 1'b0;
      err       = 1'b0;
      if ((state != IDLE) && !fall && (tmo_cnt == TMO_LAST)) begin
         state_nxt = IDLE;
         err       = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE:    if (!dat_s_p1) state_nxt = DATA;
            DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               if (dat_s_p1 && par_ok) byte_ok = 1'b1;
               else                    err     = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bit counter, parity result and inter-edge timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt  <= 3'd0;
         par_ok  <= 1'b0;
         tmo_cnt <= 16'd0;
      end else begin
         if (fall && state == IDLE) bitcnt <= 3'd0;
         if (fall && state == DATA) bitcnt <= bitcnt + 3'd1;
         if (fall && state == PARITY) par_ok <= ^{shreg, dat_s_p1};
         if (state == IDLE || fall) tmo_cnt <= 16'd0;
         else                       tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   // Data shift register, LSB arrives first
   always_ff @(posedge clk) begin
      if (fall && state == DATA) shreg <= {dat_s_p1, shreg[7:1]};
   end

   // Prefix folding and registered result/error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scancode    <= 8'h00;
         extended    <= 1'b0;
         released    <= 1'b0;
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
         ext_pend    <= 1'b0;
         rel_pend    <= 1'b0;
      end else begin
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (err) begin
            frame_error <= 1'b1;
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
         end else if (byte_ok) begin
            if (shreg == 8'hE0) begin
               ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
               rel_pend <= 1'b1;
            end else begin
               scancode   <= shreg;
               extended   <= ext_pend;
               released   <= rel_pend;
               code_valid <= 1'b1;
               ext_pend   <= 1'b0;
               rel_pend   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: 1 MHz system clock, 10 kHz PS/2 device clock.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clkps2 = 1'b1;
   logic       dataps2 = 1'b1;
   logic [7:0] scancode;
   logic       extended, released, code_valid, frame_error, busy;

   int tests_run = 0;
   int tests_failed = 0;

   int         cv_cnt = 0;
   int         fe_cnt = 0;
   int         both_cnt = 0;
   logic [7:0] cv_sc = 8'h00;
   logic       cv_ext = 1'b0;
   logic       cv_rel = 1'b0;

   ps2_scancode_rx #(
      .CLKFREQ_KHZ(1000),
      .FILTER_LEN (8),
      .TIMEOUT_US (2000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clkps2     (clkps2),
      .dataps2    (dataps2),
      .scancode   (scancode),
      .extended   (extended),
      .released   (released),
      .code_valid (code_valid),
      .frame_error(frame_error),
      .busy       (busy)
   );

   always #500 clk = ~clk;

   // Pulse monitor: counts high cycles of each strobe and captures the delivered code
   always @(negedge clk) begin
      if (code_valid) begin
         cv_cnt = cv_cnt + 1;
         cv_sc  = scancode;
         cv_ext = extended;
         cv_rel = released;
      end
      if (frame_error) fe_cnt = fe_cnt + 1;
      if (code_valid && frame_error) both_cnt = both_cnt + 1;
   end

   task automatic clear_mon();
      cv_cnt = 0;
      fe_cnt = 0;
   endtask

   // One device-to-host frame, 100 cycles per bit; optional 3-cycle low glitch after bit glitch_bit
   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                             input int nbits, input int glitch_bit);
      logic [10:0] bits;
      bits = {stop_v, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dataps2 = bits[i];
         repeat (25) @(negedge clk);
         clkps2 = 1'b0;
         repeat (50) @(negedge clk);
         clkps2 = 1'b1;
         if (i == glitch_bit) begin
            repeat (8) @(negedge clk);
            clkps2 = 1'b0;
            repeat (3) @(negedge clk);
            clkps2 = 1'b1;
            repeat (14) @(negedge clk);
         end else begin
            repeat (25) @(negedge clk);
         end
      end
      dataps2 = 1'b1;
      repeat (100) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (scancode !== 8'h00) begin tests_failed++; $display("FAIL reset_scancode: got %h expected 00", scancode); end
      tests_run++; if (extended !== 1'b0) begin tests_failed++; $display("FAIL reset_extended: got %b expected 0", extended); end
      tests_run++; if (released !== 1'b0) begin tests_failed++; $display("FAIL reset_released: got %b expected 0", released); end
      tests_run++; if (code_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_code_valid: got %b expected 0", code_valid); end
      tests_run++; if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      tests_run++; if (cv_cnt !== 0 || fe_cnt !== 0) begin tests_failed++; $display("FAIL idle_quiet: got cv=%0d fe=%0d expected 0/0", cv_cnt, fe_cnt); end
   endtask

   task automatic test_single();
      clear_mon();
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1) begin tests_failed++; $display("FAIL single_cv_count: got %0d expected 1", cv_cnt); end
      tests_run++; if (cv_sc !== 8'h1C) begin tests_failed++; $display("FAIL single_code: got %h expected 1c", cv_sc); end
      tests_run++; if (cv_ext !== 1'b0 || cv_rel !== 1'b0) begin tests_failed++; $display("FAIL single_flags: got ext=%b rel=%b expected 0/0", cv_ext, cv_rel); end
      tests_run++; if (fe_cnt !== 0) begin tests_failed++; $display("FAIL single_fe: got %0d expected 0", fe_cnt); end
      tests_run++; if (scancode !== 8'h1C) begin tests_failed++; $display("FAIL single_hold: got %h expected 1c", scancode); end
   endtask

   task automatic test_release();
      clear_mon();
      send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 0) begin tests_failed++; $display("FAIL f0_no_pulse: got %0d expected 0", cv_cnt); end
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1) begin tests_failed++; $display("FAIL rel_cv_count: got %0d expected 1", cv_cnt); end
      tests_run++; if (cv_sc !== 8'h1C || cv_rel !== 1'b1 || cv_ext !== 1'b0) begin tests_failed++; $display("FAIL rel_code: got %h ext=%b rel=%b expected 1c 0 1", cv_sc, cv_ext, cv_rel); end
   endtask

   task automatic test_ext_release();
      clear_mon();
      send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
      send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
      send_frame(8'h75, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1) begin tests_failed++; $display("FAIL extrel_cv_count: got %0d expected 1", cv_cnt); end
      tests_run++; if (cv_sc !== 8'h75 || cv_ext !== 1'b1 || cv_rel !== 1'b1) begin tests_failed++; $display("FAIL extrel_code: got %h ext=%b rel=%b expected 75 1 1", cv_sc, cv_ext, cv_rel); end
      send_frame(8'h29, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 2 || cv_sc !== 8'h29 || cv_ext !== 1'b0 || cv_rel !== 1'b0) begin tests_failed++; $display("FAIL after_extrel: got n=%0d %h ext=%b rel=%b expected 2 29 0 0", cv_cnt, cv_sc, cv_ext, cv_rel); end
   endtask

   task automatic test_errors();
      clear_mon();
      send_frame(8'h05, 1'b1, 1'b1, 11, -1);
      tests_run++; if (fe_cnt !== 1 || cv_cnt !== 0) begin tests_failed++; $display("FAIL parity_err: got fe=%0d cv=%0d expected 1/0", fe_cnt, cv_cnt); end
      tests_run++; if (scancode !== 8'h29) begin tests_failed++; $display("FAIL parity_hold: got %h expected 29", scancode); end
      clear_mon();
      send_frame(8'h05, 1'b0, 1'b0, 11, -1);
      tests_run++; if (fe_cnt !== 1 || cv_cnt !== 0) begin tests_failed++; $display("FAIL stop_err: got fe=%0d cv=%0d expected 1/0", fe_cnt, cv_cnt); end
      tests_run++; if (scancode !== 8'h29) begin tests_failed++; $display("FAIL stop_hold: got %h expected 29", scancode); end
      clear_mon();
      send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
      send_frame(8'h05, 1'b1, 1'b1, 11, -1);
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1 || cv_sc !== 8'h1C || cv_ext !== 1'b0) begin tests_failed++; $display("FAIL err_clears_pend: got n=%0d %h ext=%b expected 1 1c 0", cv_cnt, cv_sc, cv_ext); end
   endtask

   task automatic test_timeout();
      clear_mon();
      send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL tmo_busy_mid: got %b expected 1", busy); end
      repeat (2000) @(negedge clk);
      tests_run++; if (fe_cnt !== 1 || cv_cnt !== 0) begin tests_failed++; $display("FAIL tmo_err: got fe=%0d cv=%0d expected 1/0", fe_cnt, cv_cnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL tmo_busy_drop: got %b expected 0", busy); end
      send_frame(8'h5A, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1 || cv_sc !== 8'h5A || fe_cnt !== 1) begin tests_failed++; $display("FAIL tmo_recover: got n=%0d %h fe=%0d expected 1 5a 1", cv_cnt, cv_sc, fe_cnt); end
   endtask

   task automatic test_glitch();
      clear_mon();
      clkps2 = 1'b0;
      repeat (3) @(negedge clk);
      clkps2 = 1'b1;
      repeat (50) @(negedge clk);
      tests_run++; if (busy !== 1'b0 || fe_cnt !== 0 || cv_cnt !== 0) begin tests_failed++; $display("FAIL idle_glitch: got busy=%b fe=%0d cv=%0d expected 0 0 0", busy, fe_cnt, cv_cnt); end
      send_frame(8'h33, 1'b0, 1'b1, 11, 4);
      tests_run++; if (cv_cnt !== 1 || cv_sc !== 8'h33 || fe_cnt !== 0) begin tests_failed++; $display("FAIL frame_glitch: got n=%0d %h fe=%0d expected 1 33 0", cv_cnt, cv_sc, fe_cnt); end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
      send_frame(8'h77, 1'b0, 1'b1, 4, -1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (busy !== 1'b0 || scancode !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_state: got busy=%b sc=%h expected 0 00", busy, scancode); end
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      tests_run++; if (cv_cnt !== 0 || fe_cnt !== 0) begin tests_failed++; $display("FAIL rst_mid_pulses: got cv=%0d fe=%0d expected 0/0", cv_cnt, fe_cnt); end
      send_frame(8'h4B, 1'b0, 1'b1, 11, -1);
      tests_run++; if (cv_cnt !== 1 || cv_sc !== 8'h4B || cv_ext !== 1'b0 || cv_rel !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_next: got n=%0d %h ext=%b rel=%b expected 1 4b 0 0", cv_cnt, cv_sc, cv_ext, cv_rel); end
   endtask

   task automatic test_exclusive();
      tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_release();
      test_ext_release();
      test_errors();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
